round_key_buffer: RTL and testbench
===================================

ROUND_KEY_BUFFER -- requirements
Module: round_key_buffer

Interface
REQ-001 SHALL have ports: clk  input  1  clock, all logic on rising edge; rst  input  1  reset, asynchronous, active-high.
REQ-002 SHALL have ports: wr_key  input  128  round key from key schedule; wr_addr  input  4  round key index 1..11, 0 = no write.
REQ-003 SHALL have ports: wr_loaded  input  1  key schedule complete flag (level).
REQ-004 SHALL have ports: rd_start  input  1  request a key stream; rd_dir  input  1  order, 0 = forward 1..11 (encrypt), 1 = reverse 11..1 (decrypt); rd_ready  input  1  consumer accepts current key.
REQ-005 SHALL have ports: rd_key  output  128  streamed round key; rd_valid  output  1  rd_key valid; rd_round  output  4  index of rd_key; rd_last  output  1  final key of stream.
REQ-006 SHALL have ports: ready  output  1  full schedule stored, stream may start; err  output  1  one-cycle protocol-error pulse.
REQ-007 SHALL have port zeroize  input  1  clear all stored keys, present only when RKB_ZEROIZE_EN is defined.

Function
REQ-008 SHALL store 11 entries of 128 bits, indexed 1..11, each with a valid bit (11-bit mask).
REQ-009 SHALL write wr_key to entry wr_addr and set its valid bit when wr_addr is 1..11; wr_addr 0 or 12..15 SHALL be ignored without error.
REQ-010 SHALL implement states IDLE, READY, STREAM; state after reset IDLE.
REQ-011 IDLE: write to addr 1 clears all valid bits except bit 1; other writes set their bit; -> READY when mask = all ones and wr_loaded = 1 in the same cycle.
REQ-012 READY: ready = 1 (registered, asserted the cycle after entering READY state, deasserted the cycle state leaves READY).
REQ-013 READY: write to addr 1 -> IDLE with mask = bit 1 only; write to addr 2..11 overwrites entry, stays READY.
REQ-014 READY: rd_start = 1 with no valid write that cycle -> STREAM; rd_dir latched; counter = 1 (fwd) or 11 (rev); rd_start in same cycle as a valid write SHALL be ignored without err.
REQ-015 Latency: rd_start accepted in cycle N -> rd_valid = 1 with first key in cycle N+1; all rd_* outputs registered.
REQ-016 STREAM: rd_key = entry[counter], rd_round = counter, rd_valid = 1; outputs SHALL hold stable while rd_ready = 0.
REQ-017 STREAM: on rd_valid & rd_ready counter steps +1 (fwd) or -1 (rev), next key presented the following cycle; no bubbles when rd_ready held high (11 keys in 11 consecutive cycles).
REQ-018 rd_last = 1 exactly when rd_round = 11 (fwd) or 1 (rev); acceptance of the last key -> READY, rd_valid = 0 next cycle.
REQ-019 rd_key, rd_round, rd_last SHALL be 0 whenever rd_valid = 0.
REQ-020 rd_start in IDLE SHALL pulse err for one cycle and start no stream; rd_start in STREAM SHALL be ignored without err.
REQ-021 Valid writes during STREAM SHALL be dropped (storage unchanged) and pulse err for one cycle; stream continues.
REQ-022 err SHALL be a single-cycle pulse, registered, asserted the cycle after the offending event.

Reset
REQ-023 rst high SHALL immediately force state IDLE, valid mask 0, all entries 0, rd_key 0, rd_valid 0, rd_round 0, rd_last 0, ready 0, err 0.
REQ-024 rst mid-stream SHALL abort the stream; after release no key is streamed until a full schedule is rewritten and wr_loaded = 1.

Configuration
REQ-025 Macro RKB_ZEROIZE_EN defined: zeroize = 1 SHALL, next clock, clear all entries and mask, drop rd_valid/ready, state IDLE, no err; priority over writes and rd_start, below rst.
REQ-026 Macro RKB_ZEROIZE_EN undefined: zeroize port absent; storage cleared only by rst or overwritten by writes.

Verification
REQ-027 Write keys addr 1..11 (key i = 128'h i repeated), wr_loaded = 1, rd_start with rd_dir = 0, rd_ready = 1 -> ready = 1, then rd_round 1..11 in 11 consecutive cycles, matching keys, rd_last only on round 11, then READY.
REQ-028 Same fill, rd_dir = 1, rd_ready toggling 1,0,1,0 -> rounds 11..1, each key held stable during rd_ready = 0, rd_last on round 1.
REQ-029 rd_start after writing addr 1..10 only with wr_loaded = 1 -> err pulse one cycle, rd_valid stays 0, ready stays 0.
REQ-030 Write addr 5 during STREAM round 3 -> err pulse, entry 5 unchanged in stream output; write addr 1 in READY -> ready = 0, back to IDLE.
REQ-031 Assert rst at forward round 6 -> all outputs 0 immediately; with RKB_ZEROIZE_EN, zeroize in READY -> ready = 0 next cycle and subsequent rd_start gives err.

Source files
------------

// File: rtl/round_key_buffer.sv
// round_key_buffer
// Stores the 11 round keys produced by the key schedule and streams them to
// the cipher datapath in forward (encrypt) or reverse (decrypt) order over a
// valid/ready handshake. Protocol violations produce a one-cycle err pulse.
//
// Optional feature: define RKB_ZEROIZE_EN to add the zeroize input, which
// wipes all stored keys and returns the buffer to IDLE on the next clock.
module round_key_buffer (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] wr_key,
  input  logic [3:0]   wr_addr,
  input  logic         wr_loaded,
  input  logic         rd_start,
  input  logic         rd_dir,
  input  logic         rd_ready,
  output logic [127:0] rd_key,
  output logic         rd_valid,
  output logic [3:0]   rd_round,
  output logic         rd_last,
  output logic         ready,
  output logic         err
`ifdef RKB_ZEROIZE_EN
  ,
  input  logic         zeroize
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [3:0] FIRST_ROUND = 4'd1;
  localparam logic [3:0] LAST_ROUND  = 4'd11;

  state_t       r_state;
  state_t       w_state_n;
  logic [127:0] r_mem [1:11];
  logic [11:1]  r_mask;
  logic [11:1]  w_mask_n;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_n;
  logic         r_dir;
  logic         w_dir_n;

  logic         w_wr_hit;
  logic         w_we;
  logic         w_clear;
  logic         w_err_n;
  logic         w_zero;
  logic [3:0]   w_end_round;

  logic [127:0] w_key_n;
  logic [3:0]   w_round_n;
  logic         w_valid_n;
  logic         w_last_n;

  logic [127:0] r_rd_key;
  logic [3:0]   r_rd_round;
  logic         r_rd_valid;
  logic         r_rd_last;
  logic         r_ready;
  logic         r_err;

`ifdef RKB_ZEROIZE_EN
  assign w_zero = zeroize;
`else
  assign w_zero = 1'b0;
`endif

  // Addresses 0 and 12..15 are silently ignored, never flagged.
  assign w_wr_hit    = (wr_addr >= FIRST_ROUND) && (wr_addr <= LAST_ROUND);
  // Round index at which the running stream ends.
  assign w_end_round = r_dir ? FIRST_ROUND : LAST_ROUND;

  // Control state, valid mask, stream counter and direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      r_state <= IDLE;
      r_mask  <= '0;
      r_cnt   <= FIRST_ROUND;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_mask  <= w_mask_n;
      r_cnt   <= w_cnt_n;
      r_dir   <= w_dir_n;
    end
  end

  // Next-state logic: write acceptance, stream control and error detection.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_state_n = r_state;
    w_mask_n  = r_mask;
    w_cnt_n   = r_cnt;
    w_dir_n   = r_dir;
    w_we      = 1'b0;
    w_clear   = 1'b0;
    w_err_n   = 1'b0;
    if (w_zero) begin
      w_state_n = IDLE;
      w_mask_n  = '0;
      w_clear   = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_hit) begin
            w_we = 1'b1;
            // A new key 1 marks the start of a fresh schedule.
            if (wr_addr == FIRST_ROUND) w_mask_n = 11'd1;
            else                        w_mask_n[wr_addr] = 1'b1;
          end
          w_err_n = rd_start;
          if ((&w_mask_n) && wr_loaded) w_state_n = READY;
        end
        READY: begin
          if (w_wr_hit) begin
            w_we = 1'b1;
            if (wr_addr == FIRST_ROUND) begin
              w_state_n = IDLE;
              w_mask_n  = 11'd1;
            end
          end else if (rd_start) begin
            w_state_n = STREAM;
            w_dir_n   = rd_dir;
            w_cnt_n   = rd_dir ? LAST_ROUND : FIRST_ROUND;
          end
        end
        STREAM: begin
          // Storage is frozen while streaming; writes are dropped and flagged.
          w_err_n = w_wr_hit;
          if (rd_ready) begin
            if (r_cnt == w_end_round) w_state_n = READY;
            else if (r_dir)           w_cnt_n = r_cnt - 4'd1;
            else                      w_cnt_n = r_cnt + 4'd1;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  // Key storage: written only when the FSM grants a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: key storage is reset explicitly; it must read back as zero after rst.
      for (int i = 1; i <= 11; i++) r_mem[i] <= '0;
    end else if (w_clear) begin
      for (int i = 1; i <= 11; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[wr_addr] <= wr_key;
    end
  end

  // Next stream outputs, forced to zero whenever no key is being presented.
  always_comb begin
    w_valid_n = 1'b0;
    w_round_n = '0;
    w_key_n   = '0;
    w_last_n  = 1'b0;
    if (w_state_n == STREAM) begin
      w_valid_n = 1'b1;
      w_round_n = w_cnt_n;
      w_key_n   = r_mem[w_cnt_n];
      w_last_n  = (w_cnt_n == (w_dir_n ? FIRST_ROUND : LAST_ROUND));
    end
  end

  // Registered outputs so the consumer sees glitch-free, stable values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_key   <= '0;
      r_rd_round <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_key   <= w_key_n;
      r_rd_round <= w_round_n;
      r_rd_valid <= w_valid_n;
      r_rd_last  <= w_last_n;
      r_ready    <= (w_state_n == READY);
      r_err      <= w_err_n;
    end
  end

  assign rd_key   = r_rd_key;
  assign rd_round = r_rd_round;
  assign rd_valid = r_rd_valid;
  assign rd_last  = r_rd_last;
  assign ready    = r_ready;
  assign err      = r_err;

endmodule

// File: tb/tb_round_key_buffer.sv
// tb_round_key_buffer
// Table-driven, directed and randomized checks for round_key_buffer.
// Build with RKB_ZEROIZE_EN defined to also exercise the zeroize input.
module tb_round_key_buffer;

  logic         clk;
  logic         rst;
  logic [127:0] wr_key;
  logic [3:0]   wr_addr;
  logic         wr_loaded;
  logic         rd_start;
  logic         rd_dir;
  logic         rd_ready;
  logic [127:0] rd_key;
  logic         rd_valid;
  logic [3:0]   rd_round;
  logic         rd_last;
  logic         ready;
  logic         err;
`ifdef RKB_ZEROIZE_EN
  logic         zeroize;
`endif

  round_key_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .wr_key    (wr_key),
    .wr_addr   (wr_addr),
    .wr_loaded (wr_loaded),
    .rd_start  (rd_start),
    .rd_dir    (rd_dir),
    .rd_ready  (rd_ready),
    .rd_key    (rd_key),
    .rd_valid  (rd_valid),
    .rd_round  (rd_round),
    .rd_last   (rd_last),
    .ready     (ready),
    .err       (err)
`ifdef RKB_ZEROIZE_EN
    ,
    .zeroize   (zeroize)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [3:0] wr_addr;
    logic       wr_loaded;
    logic       rd_start;
    logic       rd_dir;
    logic       rd_ready;
    logic       exp_valid;
    logic [3:0] exp_round;
    logic       exp_last;
    logic       exp_ready;
    logic       exp_err;
  } vec_t;

  vec_t tbl[$];

  // Reference model: stored keys, fill mask, armed flag and the queue of
  // rounds still to be delivered in the current stream.
  logic [127:0] m_keys [1:11];
  bit   [11:1]  m_mask;
  bit           m_armed;
  int           m_q[$];
  bit           m_err;

  function automatic logic [127:0] key_of(input logic [3:0] i);
    return {32{i}};
  endfunction

  // Output bundle: {rd_key, rd_round, rd_valid, rd_last, ready, err}.
  function automatic logic [135:0] dut_out();
    return {rd_key, rd_round, rd_valid, rd_last, ready, err};
  endfunction

  function automatic logic [135:0] exp_pack(input logic v, input logic [3:0] r,
                                             input logic l, input logic rdy, input logic e);
    logic [127:0] k;
    logic [3:0]   rr;
    k  = v ? key_of(r) : 128'd0;
    rr = v ? r : 4'd0;
    return {k, rr, v, l, rdy, e};
  endfunction

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [127:0] k, input logic ld,
                       input logic st, input logic dir, input logic rdy);
    wr_addr   = a;
    wr_key    = k;
    wr_loaded = ld;
    rd_start  = st;
    rd_dir    = dir;
    rd_ready  = rdy;
  endtask

  task automatic add(input logic [3:0] a, input logic ld, input logic st, input logic dir,
                     input logic rdy, input logic ev, input logic [3:0] er,
                     input logic el, input logic erdy, input logic ee);
    vec_t v;
    v.wr_addr = a;  v.wr_loaded = ld; v.rd_start = st; v.rd_dir = dir; v.rd_ready = rdy;
    v.exp_valid = ev; v.exp_round = er; v.exp_last = el; v.exp_ready = erdy; v.exp_err = ee;
    tbl.push_back(v);
  endtask

  // Write a full schedule 1..11 with wr_loaded high, then go quiet.
  task automatic fill();
    for (int i = 1; i <= 11; i++) begin
      drive(4'(i), key_of(4'(i)), 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    drive(4'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic void model_reset();
    for (int i = 1; i <= 11; i++) m_keys[i] = '0;
    m_mask  = '0;
    m_armed = 1'b0;
    m_q.delete();
    m_err   = 1'b0;
  endfunction

  function automatic void model_step(input logic [3:0] a, input logic [127:0] k,
                                     input logic ld, input logic st, input logic dir,
                                     input logic rdy);
    bit hit;
    hit   = (a >= 1) && (a <= 11);
    m_err = 1'b0;
    if (m_q.size() > 0) begin
      if (hit) m_err = 1'b1;
      if (rdy) void'(m_q.pop_front());
    end else if (m_armed) begin
      if (hit) begin
        m_keys[a] = k;
        if (a == 1) begin
          m_armed = 1'b0;
          m_mask  = 11'd1;
        end
      end else if (st) begin
        for (int i = 1; i <= 11; i++) m_q.push_back(dir ? 12 - i : i);
      end
    end else begin
      if (hit) begin
        m_keys[a] = k;
        if (a == 1) m_mask = 11'd1;
        else        m_mask[a] = 1'b1;
      end
      if (st) m_err = 1'b1;
      if ((&m_mask) && ld) m_armed = 1'b1;
    end
  endfunction

  function automatic logic [135:0] model_out();
    logic [127:0] k;
    logic [3:0]   r;
    logic         v;
    logic         l;
    k = '0; r = '0; v = 1'b0; l = 1'b0;
    if (m_q.size() > 0) begin
      v = 1'b1;
      r = 4'(m_q[0]);
      k = m_keys[m_q[0]];
      l = (m_q.size() == 1);
    end
    return {k, r, v, l, m_armed && !v, m_err};
  endfunction

  initial begin
    int exp_r;
    logic tog;
    n_vec = 0;
    n_bad = 0;
`ifdef RKB_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    drive(4'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("reset_state", dut_out(), 136'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ---- Table: partial fill error, ignored addresses, forward stream ----
    for (int i = 1; i <= 10; i++) add(4'(i), 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(4'd0,  1, 1, 0, 0, 0, 0, 0, 0, 1);   // start before schedule complete
    add(4'd0,  1, 0, 0, 0, 0, 0, 0, 0, 0);   // err lasts one cycle
    add(4'd12, 1, 0, 0, 0, 0, 0, 0, 0, 0);   // out-of-range address ignored
    add(4'd15, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(4'd11, 1, 0, 0, 0, 0, 0, 0, 1, 0);   // schedule complete -> ready
    add(4'd3,  0, 1, 0, 0, 0, 0, 0, 1, 0);   // start with a write: ignored
    add(4'd0,  0, 1, 0, 1, 1, 1, 0, 0, 0);   // forward stream, round 1
    for (int r = 2; r <= 11; r++) add(4'd0, 0, 0, 0, 1, 1, 4'(r), r == 11, 0, 0);
    add(4'd0,  0, 0, 0, 1, 0, 0, 0, 1, 0);   // last accepted -> READY
    foreach (tbl[i]) begin
      drive(tbl[i].wr_addr, key_of(tbl[i].wr_addr), tbl[i].wr_loaded,
            tbl[i].rd_start, tbl[i].rd_dir, tbl[i].rd_ready);
      @(negedge clk);
      check($sformatf("tbl[%0d]", i), dut_out(),
            exp_pack(tbl[i].exp_valid, tbl[i].exp_round, tbl[i].exp_last,
                     tbl[i].exp_ready, tbl[i].exp_err));
    end

    // ---- Reverse stream with rd_ready toggling ----
    drive(4'd0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("rev_first", dut_out(), exp_pack(1, 4'd11, 0, 0, 0));
    exp_r = 11;
    tog   = 1'b1;
    for (int c = 0; c < 30 && exp_r > 0; c++) begin
      drive(4'd0, '0, 1'b0, 1'b0, 1'b1, tog);
      @(negedge clk);
      if (tog) exp_r--;
      if (exp_r > 0) check($sformatf("rev_c%0d", c), dut_out(), exp_pack(1, 4'(exp_r), exp_r == 1, 0, 0));
      else           check("rev_done", dut_out(), exp_pack(0, 0, 0, 1, 0));
      tog = ~tog;
    end

    // ---- Write during stream, then return to IDLE via addr 1 ----
    drive(4'd0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive(4'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("wr_strm_r3", dut_out(), exp_pack(1, 4'd3, 0, 0, 0));
    drive(4'd5, {128{1'b1}}, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("wr_strm_err", dut_out(), exp_pack(1, 4'd4, 0, 0, 1));
    for (int r = 5; r <= 11; r++) begin
      drive(4'd0, '0, 1'b0, 1'b1, 1'b0, 1'b1);   // rd_start in STREAM is ignored
      @(negedge clk);
      check($sformatf("wr_strm_r%0d", r), dut_out(), exp_pack(1, 4'(r), r == 11, 0, 0));
    end
    drive(4'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("wr_strm_end", dut_out(), exp_pack(0, 0, 0, 1, 0));
    drive(4'd1, key_of(4'd1), 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("addr1_ready_drop", dut_out(), exp_pack(0, 0, 0, 0, 0));
    drive(4'd0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("idle_start_err", dut_out(), exp_pack(0, 0, 0, 0, 1));

    // ---- Asynchronous reset mid-stream ----
    fill();
    @(negedge clk);
    check("refill_ready", dut_out(), exp_pack(0, 0, 0, 1, 0));
    drive(4'd0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive(4'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("rst_r6", dut_out(), exp_pack(1, 4'd6, 0, 0, 0));
    #2 rst = 1'b1;
    #1;
    check("rst_async", dut_out(), 136'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'd0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("post_rst_start", dut_out(), exp_pack(0, 0, 0, 0, 1));
    for (int i = 2; i <= 11; i++) begin
      drive(4'(i), key_of(4'(i)), 1'b1, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
    end
    check("no_key1_not_ready", dut_out(), exp_pack(0, 0, 0, 0, 0));
    fill();
    @(negedge clk);
    check("rst_refill_ready", dut_out(), exp_pack(0, 0, 0, 1, 0));

`ifdef RKB_ZEROIZE_EN
    // ---- Zeroize from READY ----
    zeroize = 1'b1;
    drive(4'd0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("zeroize_ready", dut_out(), exp_pack(0, 0, 0, 0, 0));
    zeroize = 1'b0;
    @(negedge clk);
    check("zeroize_start_err", dut_out(), exp_pack(0, 0, 0, 0, 1));
`endif

    // ---- Randomized traffic against the reference model ----
    drive(4'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0]   a;
      logic [127:0] k;
      int           p;
      p = $urandom_range(0, 99);
      if (p < 2)       a = 4'd1;
      else if (p < 40) a = 4'($urandom_range(2, 11));
      else if (p < 45) a = 4'($urandom_range(12, 15));
      else             a = 4'd0;
      k = {$urandom, $urandom, $urandom, $urandom};
      drive(a, k, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6);
      model_step(wr_addr, wr_key, wr_loaded, rd_start, rd_dir, rd_ready);
      @(negedge clk);
      check($sformatf("rand_c%0d", c), dut_out(), model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
